vx_raster_extents_ctrl: RTL and testbench
=========================================

Name: VX_raster_extents_ctrl

Overview:
Shared tile-extents engine for raster setup. Arbitrates round-robin among NUM_REQS primitive producers and latches one primitive (3 edges × 3 coefficients). Computes the three edge extents one edge per cycle on a single shared extents datapath, then holds the result on a valid/ready output. It sits between the per-slice setup requesters and the tile binning stage.

Parameters:
NUM_REQS, 4, number of requesting ports (≥1); index width REQ_BITS = max(1, clog2(NUM_REQS))
TILE_LOGSIZE, 5, log2 tile size; left-shift applied to each edge coefficient
DATA_BITS, `RASTER_DATA_BITS (32), width of every edge coefficient and extent
TAG_WIDTH, 8, opaque primitive tag carried through unchanged

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQS  per-port primitive valid
req_ready  out  NUM_REQS  per-port accept (one-hot or zero)
req_edges  in  NUM_REQS×3×3×DATA_BITS  edge coefficients [port][edge][a,b,c], two's complement
req_tag  in  NUM_REQS×TAG_WIDTH  per-port tag
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_edges  out  3×3×DATA_BITS  latched edges of accepted primitive
out_extents  out  3×DATA_BITS  computed extents, index = edge
out_tag  out  TAG_WIDTH  latched tag
out_req_idx  out  REQ_BITS  port the primitive came from

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state=IDLE, RR pointer=0, edge counter=0, out_valid=0, req_ready=0, out_extents/out_edges/out_tag/out_req_idx=0. Reset mid-CALC or mid-DONE discards the primitive; no output is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE: if any req_valid, grant = first valid port at or after RR pointer (wrapping). req_ready[grant]=1 combinationally in the same cycle; all other bits are 0. On the accept edge, latch edges/tag/index, set counter=0, go to CALC, and set RR pointer=(grant+1) mod NUM_REQS. If no request is valid, req_ready=0 and the FSM stays in IDLE.
- CALC: one edge per cycle, counter 0→1→2. For edge e with a=edges[e][0] and b=edges[e][1]:
  - ext[e] = (a[MSB]==0 ? a<<TILE_LOGSIZE : 0) + (b[MSB]==0 ? b<<TILE_LOGSIZE : 0).
  - Shifts and the sum are truncated to DATA_BITS. There is no saturation and no overflow flag.
  - Coefficient c is ignored; it passes through only on out_edges.
  - ext[e] is registered at the end of its cycle. After counter==2, go to DONE.
  - req_ready=0 throughout CALC.
- DONE: out_valid=1; all out_* signals stay stable until out_ready.
  - On out_valid&&out_ready: out_valid falls next cycle.
  - In that same cycle the arbiter may accept a new primitive (req_ready as in IDLE). If it does, go to CALC; otherwise go to IDLE.
- Latency: accept at cycle T → out_valid at T+4. Peak throughput 1 primitive per 4 cycles with out_ready held high.
- out_valid never drops without a handshake; out_* never changes while out_valid && !out_ready.
- NUM_REQS=1: arbiter degenerates to pass-through; RR pointer stays 0.
- Requester valid deasserting before grant is legal; nothing is latched for it.

Test Plan:
- Single request on port 0, edges[0]={a=3,b=-2}, [1]={1,2}, [2]={-1,-1}, tag=0x5A, out_ready=1 → req_ready[0] in accept cycle; out_valid 4 cycles later; extents={96,96,0}, tag 0x5A, out_req_idx=0.
- All 4 ports valid continuously → grants in order 0,1,2,3,0; each result's out_req_idx matches the port; one result every 4 cycles.
- Overflow: a=0x0800_0000, b=0x0000_0001 → extent = 0x0000_0020 (the a-term wraps to 0).
- Backpressure: out_ready=0 for 10 cycles in DONE while port 2 is valid → out_* stable, req_ready=0 throughout; on out_ready=1, port 2 is accepted in the same cycle and its result appears 4 cycles later.
- Reset asserted in the second CALC cycle → out_valid=0 and all outputs 0 immediately; after release, the next grant starts from port 0 and no stale result is emitted.
- Port 1 valid for 1 cycle while the FSM is in CALC, then dropped → never granted and no output for it.

Source files
------------

// File: rtl/vx_raster_extents_ctrl.sv
// Round-robin primitive arbiter feeding a shared edge-extents datapath.
// One primitive is latched, its three extents are computed one edge per cycle, then held on valid/ready.
module vx_raster_extents_ctrl #(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned TILE_LOGSIZE = 5,
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned TAG_WIDTH    = 8,
    localparam int unsigned REQ_BITS    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [NUM_REQS-1:0]             req_valid,
    output logic [NUM_REQS-1:0]             req_ready,
    input  logic [NUM_REQS*9*DATA_BITS-1:0] req_edges,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]   req_tag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [9*DATA_BITS-1:0]          out_edges,
    output logic [3*DATA_BITS-1:0]          out_extents,
    output logic [TAG_WIDTH-1:0]            out_tag,
    output logic [REQ_BITS-1:0]             out_req_idx
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e                                  state_q;
    logic [REQ_BITS-1:0]                     rr_q, rr_d, grant, idx_q;
    logic                                    grant_found, can_accept, accept;
    logic [1:0]                              cnt_q;
    logic                                    valid_q;
    logic [2:0][2:0][DATA_BITS-1:0]          edges_q;
    logic [2:0][DATA_BITS-1:0]               ext_q;
    logic [TAG_WIDTH-1:0]                    tag_q;
    logic [NUM_REQS-1:0][2:0][2:0][DATA_BITS-1:0] req_edges_a;
    logic [NUM_REQS-1:0][TAG_WIDTH-1:0]      req_tag_a;
    logic [DATA_BITS-1:0]                    coef_a, coef_b, term_a, term_b, ext_calc;

    assign req_edges_a = req_edges;
    assign req_tag_a   = req_tag;

    // Two passes: first valid port at/after the pointer, else lowest valid port (the wrap-around).
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (!grant_found && req_valid[i] && (REQ_BITS'(i) >= rr_q)) begin
                grant       = REQ_BITS'(i);
                grant_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (!grant_found && req_valid[i]) begin
                grant       = REQ_BITS'(i);
                grant_found = 1'b1;
            end
        end
    end

    assign can_accept = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept     = can_accept && grant_found;
    assign req_ready  = accept ? (NUM_REQS'(1) << grant) : '0;
    assign rr_d       = (grant == REQ_BITS'(NUM_REQS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        coef_a = edges_q[0][0];
        coef_b = edges_q[0][1];
        case (cnt_q)
            2'd1: begin
                coef_a = edges_q[1][0];
                coef_b = edges_q[1][1];
            end
            2'd2: begin
                coef_a = edges_q[2][0];
                coef_b = edges_q[2][1];
            end
            default: ;
        endcase
        term_a   = coef_a[DATA_BITS-1] ? '0 : (coef_a << TILE_LOGSIZE);
        term_b   = coef_b[DATA_BITS-1] ? '0 : (coef_b << TILE_LOGSIZE);
        ext_calc = term_a + term_b;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            edges_q <= '0;
            ext_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
        end else begin
            if (accept) begin
                state_q <= CALC;
                cnt_q   <= '0;
                edges_q <= req_edges_a[grant];
                tag_q   <= req_tag_a[grant];
                idx_q   <= grant;
                rr_q    <= rr_d;
            end
            case (state_q)
                CALC: begin
                    case (cnt_q)
                        2'd0:    ext_q[0] <= ext_calc;
                        2'd1:    ext_q[1] <= ext_calc;
                        default: ext_q[2] <= ext_calc;
                    endcase
                    if (cnt_q == 2'd2) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        if (!accept) state_q <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid   = valid_q;
    assign out_edges   = edges_q;
    assign out_extents = ext_q;
    assign out_tag     = tag_q;
    assign out_req_idx = idx_q;

endmodule

// File: tb/tb_vx_raster_extents_ctrl.sv
// Directed bench for vx_raster_extents_ctrl: vector table plus arbitration, backpressure and reset sequences.
module tb_vx_raster_extents_ctrl;

    typedef logic [287:0] w_t;

    typedef struct {
        int unsigned port;
        logic [7:0]  tag;
        logic [31:0] a0, b0, a1, b1, a2, b2;
        logic [31:0] x0, x1, x2;
    } vec_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [1151:0] req_edges = '0;
    logic [31:0]  req_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [287:0] out_edges;
    logic [95:0]  out_extents;
    logic [7:0]   out_tag;
    logic [1:0]   out_req_idx;

    int total = 0;
    int bad   = 0;
    vec_t vecs[4];

    vx_raster_extents_ctrl #(
        .NUM_REQS(4),
        .TILE_LOGSIZE(5),
        .DATA_BITS(32),
        .TAG_WIDTH(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_edges(req_edges),
        .req_tag(req_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_edges(out_edges),
        .out_extents(out_extents),
        .out_tag(out_tag),
        .out_req_idx(out_req_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input w_t got, input w_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] cval(input logic [7:0] tag, input int e);
        return {16'hC0C0, tag, 8'(e)};
    endfunction

    function automatic w_t blk_of(input vec_t v);
        logic [8:0][31:0] blk;
        blk[0] = v.a0; blk[1] = v.b0; blk[2] = cval(v.tag, 0);
        blk[3] = v.a1; blk[4] = v.b1; blk[5] = cval(v.tag, 1);
        blk[6] = v.a2; blk[7] = v.b2; blk[8] = cval(v.tag, 2);
        return blk;
    endfunction

    function automatic int vec_of(input int p);
        case (p)
            0: return 0;
            1: return 1;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic load_port(input vec_t v);
        req_edges[v.port*288 +: 288] = blk_of(v);
        req_tag[v.port*8 +: 8]       = v.tag;
    endtask

    task automatic check_out(input string pfx, input vec_t v);
        check({pfx, "_ext"},   w_t'(out_extents), w_t'({v.x2, v.x1, v.x0}));
        check({pfx, "_tag"},   w_t'(out_tag), w_t'(v.tag));
        check({pfx, "_idx"},   w_t'(out_req_idx), w_t'(v.port));
        check({pfx, "_edges"}, out_edges, blk_of(v));
    endtask

    // Counts negedges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(input int start, output int lat);
        lat = start;
        do begin
            @(negedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int n;
        int lat;
        logic [3:0] oh;
        v  = vecs[i];
        oh = 4'b0001 << v.port;
        @(negedge clk);
        load_port(v);
        req_valid = oh;
        out_ready = 1'b1;
        #1;
        n = 0;
        while (!req_ready[v.port] && n < 10) begin
            @(negedge clk); #1;
            n++;
        end
        check($sformatf("v%0d_ready", i), w_t'(req_ready), w_t'(oh));
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(0, lat);
        check($sformatf("v%0d_latency", i), w_t'(lat), w_t'(4));
        check_out($sformatf("v%0d", i), v);
        @(negedge clk); #1;
        check($sformatf("v%0d_valid_drop", i), w_t'(out_valid), w_t'(1'b0));
    endtask

    initial begin
        int lat;
        int g, r, last, gp, cyc, stale;
        logic [3:0] rr_order;

        vecs[0] = '{32'd0, 8'h5A, 32'd3, 32'hFFFF_FFFE, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'd96, 32'd96, 32'd0};
        vecs[1] = '{32'd1, 8'hA1, 32'h0800_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'd0,
                    32'h0400_0000, 32'h0400_0000, 32'h0000_0020, 32'hFFFF_FFE0, 32'd0};
        vecs[2] = '{32'd3, 8'h33, 32'h8000_0000, 32'd5, 32'd10, 32'h8000_0001, 32'd0, 32'd0,
                    32'd160, 32'd320, 32'd0};
        vecs[3] = '{32'd2, 8'hC2, 32'hFFFF_FFFB, 32'd100, 32'd1, 32'd1, 32'h0100_0000, 32'hFFFF_FFFF,
                    32'd3200, 32'd64, 32'h2000_0000};

        repeat (3) @(negedge clk);
        #1;
        check("reset_state", w_t'({out_valid, req_ready, out_extents, out_tag, out_req_idx}), '0);
        check("reset_edges", out_edges, '0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Round-robin with all ports requesting continuously; pointer restarts at 0 after reset.
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int p = 0; p < 4; p++) load_port(vecs[vec_of(p)]);
        req_valid = 4'hF;
        out_ready = 1'b1;
        g = 0; r = 0; last = 0; cyc = 0;
        rr_order = '0;
        while (cyc < 60 && r < 5) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (g == 5) req_valid = '0;
            #1;
            if (out_valid) begin
                check($sformatf("rr_res%0d_idx", r), w_t'(out_req_idx), w_t'(r % 4));
                check($sformatf("rr_res%0d_ext", r), w_t'(out_extents),
                      w_t'({vecs[vec_of(r % 4)].x2, vecs[vec_of(r % 4)].x1, vecs[vec_of(r % 4)].x0}));
                r++;
            end
            if (req_ready != '0) begin
                gp = 0;
                for (int p = 0; p < 4; p++) if (req_ready[p]) gp = p;
                check($sformatf("rr_grant%0d", g), w_t'(gp), w_t'(g % 4));
                if (g > 0) check($sformatf("rr_spacing%0d", g), w_t'(cyc - last), w_t'(4));
                last = cyc;
                g++;
            end
            cyc++;
        end
        check("rr_grant_count", w_t'(g), w_t'(5));
        check("rr_result_count", w_t'(r), w_t'(5));
        repeat (2) @(negedge clk);

        // Backpressure: hold DONE for 10 cycles while port 2 waits.
        @(negedge clk);
        load_port(vecs[0]);
        load_port(vecs[3]);
        req_valid = 4'b0001;
        out_ready = 1'b0;
        #1;
        check("bp_first_ready", w_t'(req_ready), w_t'(4'b0001));
        @(posedge clk); #1;
        req_valid = 4'b0100;
        wait_out(0, lat);
        check("bp_latency", w_t'(lat), w_t'(4));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            check($sformatf("bp_hold%0d", k),
                  w_t'({out_valid, req_ready, out_extents, out_tag, out_req_idx}),
                  w_t'({1'b1, 4'b0000, vecs[0].x2, vecs[0].x1, vecs[0].x0, vecs[0].tag, 2'd0}));
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", w_t'(req_ready), w_t'(4'b0100));
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(0, lat);
        check("bp_p2_latency", w_t'(lat), w_t'(4));
        check_out("bp_p2", vecs[3]);
        repeat (2) @(negedge clk);

        // Reset in the second CALC cycle of a port-1 primitive.
        @(negedge clk);
        load_port(vecs[1]);
        load_port(vecs[2]);
        req_valid = 4'b0010;
        #1;
        check("rst_pre_ready", w_t'(req_ready), w_t'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_pre_tag", w_t'(out_tag), w_t'(vecs[1].tag));
        resetn = 1'b0;
        #1;
        check("rst_mid_outputs", w_t'({out_valid, req_ready, out_extents, out_tag, out_req_idx}), '0);
        check("rst_mid_edges", out_edges, '0);
        @(negedge clk);
        resetn = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (out_valid || req_ready != '0) stale++;
        end
        check("rst_no_stale", w_t'(stale), '0);
        req_valid = 4'b1010;
        #1;
        check("rst_grant_from0", w_t'(req_ready), w_t'(4'b0010));
        @(posedge clk); #1;
        req_valid = '0;
        wait_out(0, lat);
        check("rst_after_latency", w_t'(lat), w_t'(4));
        check_out("rst_after", vecs[1]);
        repeat (2) @(negedge clk);

        // Port 1 pulses for one cycle during CALC and must be ignored.
        @(negedge clk);
        load_port(vecs[0]);
        req_valid = 4'b0001;
        #1;
        check("pulse_p0_ready", w_t'(req_ready), w_t'(4'b0001));
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("pulse_ready_in_calc", w_t'(req_ready), '0);
        @(negedge clk);
        req_valid = '0;
        #1;
        wait_out(2, lat);
        check("pulse_latency", w_t'(lat), w_t'(4));
        check_out("pulse_p0", vecs[0]);
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (out_valid || req_ready != '0) stale++;
        end
        check("pulse_never_granted", w_t'(stale), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
